// File: rtl/arbiters.sv
// Shared arbiter definitions: FSM state encoding and owner-index width helper.
package arbiters;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2
   } ArbiterState;

   // Width of an index into a set of n requesters; never narrower than one bit.
   function automatic int ownerWidth(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin search: first set request at or after startIndex, with wrap.
module round_robin_picker
   import arbiters::*;
#(
   parameter int NUMBER_OF_CACHES = 4,
   parameter int OWNER_WIDTH      = ownerWidth(NUMBER_OF_CACHES)
) (
   input  logic [NUMBER_OF_CACHES-1:0] requests,
   input  logic [OWNER_WIDTH-1:0]      startIndex,
   output logic [NUMBER_OF_CACHES-1:0] grantOneHot,
   output logic [OWNER_WIDTH-1:0]      grantIndex,
   output logic                        grantValid
);

   // Walk the request vector starting at startIndex and take the first hit.
   always_comb begin
      int candidate;
      grantOneHot = '0;
      grantIndex  = '0;
      grantValid  = 1'b0;
      candidate   = 0;
      for (int offset = 0; offset < NUMBER_OF_CACHES; offset++) begin
         candidate = (int'(startIndex) + offset) % NUMBER_OF_CACHES;
         if (!grantValid && requests[candidate]) begin
            grantValid             = 1'b1;
            grantOneHot[candidate] = 1'b1;
            grantIndex             = OWNER_WIDTH'(candidate);
         end
      end
   end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Bus arbiter for the snoopy invalidate protocol: round-robin CPU tenure plus
// selection of at most one snoopy cache to source read data instead of RAM.
module snoopy_bus_arbiter
   import arbiters::*;
#(
   parameter  int NUMBER_OF_CACHES = 4,
   localparam int OWNER_WIDTH      = ownerWidth(NUMBER_OF_CACHES)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUMBER_OF_CACHES-1:0] cpuRequests,
   input  logic [NUMBER_OF_CACHES-1:0] snoopyRequests,
   output logic [NUMBER_OF_CACHES-1:0] cpuGrants,
   output logic [NUMBER_OF_CACHES-1:0] snoopyGrants,
   output logic [OWNER_WIDTH-1:0]      busOwner,
   output logic                        busBusy
);

   localparam logic [OWNER_WIDTH-1:0] LAST_INDEX = OWNER_WIDTH'(NUMBER_OF_CACHES - 1);

   ArbiterState                 state;
   ArbiterState                 stateNext;
   logic [OWNER_WIDTH-1:0]      lastOwner;
   logic [OWNER_WIDTH-1:0]      lastOwnerNext;
   logic [OWNER_WIDTH-1:0]      busOwnerNext;
   logic [NUMBER_OF_CACHES-1:0] cpuGrantsNext;
   logic [NUMBER_OF_CACHES-1:0] snoopyGrantsNext;

   logic [NUMBER_OF_CACHES-1:0] ownerMask;
   logic [NUMBER_OF_CACHES-1:0] eligibleSnoopers;
   logic [NUMBER_OF_CACHES-1:0] cpuWinnerOneHot;
   logic [OWNER_WIDTH-1:0]      cpuWinnerIndex;
   logic                        cpuWinnerValid;
   logic [NUMBER_OF_CACHES-1:0] snoopWinnerOneHot;
   logic [OWNER_WIDTH-1:0]      snoopWinnerIndex;
   logic                        snoopWinnerValid;

   // Successor index modulo the number of caches.
   function automatic logic [OWNER_WIDTH-1:0] nextIndex(input logic [OWNER_WIDTH-1:0] index);
      if (index >= LAST_INDEX) begin
         return '0;
      end
      return index + 1'b1;
   endfunction

   // The owner is masked out so a cache never sources data to itself.
   always_comb begin
      ownerMask           = '0;
      ownerMask[busOwner] = 1'b1;
      eligibleSnoopers    = snoopyRequests & ~ownerMask;
   end

   round_robin_picker #(
      .NUMBER_OF_CACHES (NUMBER_OF_CACHES),
      .OWNER_WIDTH      (OWNER_WIDTH)
   ) cpuPicker (
      .requests    (cpuRequests),
      .startIndex  (nextIndex(lastOwner)),
      .grantOneHot (cpuWinnerOneHot),
      .grantIndex  (cpuWinnerIndex),
      .grantValid  (cpuWinnerValid)
   );

   round_robin_picker #(
      .NUMBER_OF_CACHES (NUMBER_OF_CACHES),
      .OWNER_WIDTH      (OWNER_WIDTH)
   ) snoopPicker (
      .requests    (eligibleSnoopers),
      .startIndex  (nextIndex(busOwner)),
      .grantOneHot (snoopWinnerOneHot),
      .grantIndex  (snoopWinnerIndex),
      .grantValid  (snoopWinnerValid)
   );

   // State and grant registers; reset clears everything at once, even mid-tenure.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         lastOwner    <= LAST_INDEX;
         busOwner     <= '0;
         cpuGrants    <= '0;
         snoopyGrants <= '0;
      end else begin
         state        <= stateNext;
         lastOwner    <= lastOwnerNext;
         busOwner     <= busOwnerNext;
         cpuGrants    <= cpuGrantsNext;
         snoopyGrants <= snoopyGrantsNext;
      end
   end

   // Next-state and next-grant logic; registers hold unless a branch changes them.
   always_comb begin
      stateNext        = state;
      lastOwnerNext    = lastOwner;
      busOwnerNext     = busOwner;
      cpuGrantsNext    = cpuGrants;
      snoopyGrantsNext = snoopyGrants;
      case (state)
         IDLE: begin
            cpuGrantsNext    = '0;
            snoopyGrantsNext = '0;
            if (cpuWinnerValid) begin
               cpuGrantsNext = cpuWinnerOneHot;
               busOwnerNext  = cpuWinnerIndex;
               lastOwnerNext = cpuWinnerIndex;
               stateNext     = GRANTED;
            end
         end
         GRANTED: begin
            if (!cpuRequests[busOwner]) begin
               // Release wins over any snoopy request arriving in the same cycle.
               cpuGrantsNext    = '0;
               snoopyGrantsNext = '0;
               stateNext        = RELEASE;
            end else if (snoopyGrants == '0) begin
               if (snoopWinnerValid && (snoopWinnerIndex != busOwner)) begin
                  snoopyGrantsNext = snoopWinnerOneHot;
               end
            end else if ((snoopyGrants & snoopyRequests) == '0) begin
               // Granted snoopy withdrew; a fresh pick happens next cycle.
               snoopyGrantsNext = '0;
            end
         end
         RELEASE: begin
            cpuGrantsNext    = '0;
            snoopyGrantsNext = '0;
            stateNext        = IDLE;
         end
         default: begin
            cpuGrantsNext    = '0;
            snoopyGrantsNext = '0;
            stateNext        = IDLE;
         end
      endcase
   end

   assign busBusy = (state == GRANTED);

endmodule

// File: doc/snoopy_bus_arbiter.md
# snoopy_bus_arbiter

Arbiter that produces `cpuGrants` and `snoopyGrants` for the snoopy invalidate-protocol bus. It shares the single bus tenure round-robin between the per-cache CPU controllers. During a tenure it selects at most one snoopy controller to source read data in place of RAM. All grants are registered, one-hot or zero, and drive the bus multiplexer directly.

## Interface
- `NUMBER_OF_CACHES`, default 4: number of caches on the bus; must be ≥ 2.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `cpuRequests`  in  NUMBER_OF_CACHES: bit i high means CPU controller i wants the bus; held high for the whole transaction.
- `snoopyRequests`  in  NUMBER_OF_CACHES: bit i high means snoopy i holds the addressed line and will supply data.
- `cpuGrants`  out  NUMBER_OF_CACHES: one-hot bus ownership, or zero.
- `snoopyGrants`  out  NUMBER_OF_CACHES: one-hot data-source select, or zero (RAM sources data).
- `busOwner`  out  OWNER_WIDTH = max(1, $clog2(NUMBER_OF_CACHES)): index of the current or most recent owner.
- `busBusy`  out  1: high while in GRANTED.

## Operation
- States: IDLE, GRANTED, RELEASE.
- IDLE:
  - If `cpuRequests` ≠ 0, pick the winner by searching from `lastOwner+1` mod N upward with wrap.
  - Load `cpuGrants` with the one-hot winner, set `busOwner` and `lastOwner` to the winner, and go to GRANTED.
  - Otherwise stay in IDLE with all grants 0.
- GRANTED:
  - If `cpuRequests[busOwner]` = 0, clear `cpuGrants` and `snoopyGrants` and go to RELEASE.
  - Otherwise, snoopy selection applies:
    - Eligible set = `snoopyRequests` with bit `busOwner` masked off. The owner never snoops itself.
    - If `snoopyGrants` = 0 and the eligible set ≠ 0, grant the first eligible bit searching from `busOwner+1` mod N.
    - If `snoopyGrants` ≠ 0 and the granted snoopy's request bit is 0, clear `snoopyGrants`. A new selection is allowed from the following cycle.
    - A granted snoopy keeps its grant while its request stays high, even if a higher-ordered snoopy starts requesting.
- RELEASE: all grants 0 for exactly one cycle, then go to IDLE. This gives a bus turnaround gap.
- `lastOwner` fairness register:
  - Reset value N-1, so cache 0 is searched first.
  - Updates only on a grant.
- Requests that drop while not granted are simply not selected. Inputs are not latched.
- Reset:
  - Asynchronous: state goes to IDLE, and `cpuGrants`, `snoopyGrants`, `busOwner`, `busBusy` all go to 0 immediately, including mid-tenure.
  - `lastOwner` returns to N-1.

## Timing
- Request seen high at edge t in IDLE: grant visible after edge t (latency 1).
- Owner request seen low at edge t: grants low after t; RELEASE for t..t+1; IDLE evaluated at t+1; next grant visible after t+2.
- Snoopy request seen at edge t while GRANTED with no snoopy grant: `snoopyGrants` visible after t.
- Snoopy request drop seen at edge t: `snoopyGrants` low after t.
- `snoopyGrants` is never nonzero when `cpuGrants` = 0.
- `cpuGrants` and `snoopyGrants` are never multi-hot.
- Owner drops its request in the same cycle a snoopy requests: release takes priority and no snoopy grant is issued.

## Structure
- Shared package `arbiters`:
  - enum `ArbiterState` {IDLE, GRANTED, RELEASE}.
  - Function computing OWNER_WIDTH.
- Sub-module `round_robin_picker`, combinational and instantiated twice (CPU and snoopy):
  - Inputs: request vector, start index.
  - Outputs: one-hot result, index, valid.
- Top level holds the FSM and registers. Expected size is about 200 lines.

## Test plan
All scenarios use N=4.
- Reset asserted, then released with no requests: all outputs 0, `busBusy` 0, state IDLE for 10 cycles.
- `cpuRequests`=0101 after reset:
  - `cpuGrants`=0001 one cycle later.
  - Drop bit 0: `cpuGrants`=0000 for two cycles, then 0100 with `busOwner`=2.
- `cpuRequests`=1111 continuously, each owner dropping and reasserting its request 2 cycles after being granted: grant order 0,1,2,3,0,1.
- Owner 1, `snoopyRequests`=1011: `snoopyGrants`=1000.
  - Then raise bit 2 (1111): `snoopyGrants` stays 1000.
  - Drop bit 3: `snoopyGrants`=0000, then 0100 the next cycle.
- Owner 1, `snoopyRequests`=0010 only: `snoopyGrants` stays 0000 for the whole tenure.
- Assert reset mid-GRANTED (owner 2, `snoopyGrants`=0001) between edges:
  - All outputs 0 without a clock edge.
  - After release with `cpuRequests`=1100, `cpuGrants`=0100.
